apb_master: RTL and testbench

- APB initiator that turns a simple valid/ready command interface into APB3-style SETUP/ACCESS transfers on the peripheral bus.
- It is the requester side for our APB peripherals, for example the GPIO block with its 4-bit address map and registered PREADY.
- It issues one transfer at a time, returns a single-cycle response with read data, and aborts any transfer whose slave never raises PREADY (bus timeout).

---
 rtl/apb_master.sv | 126 ++++++++++++
 tb/tb_apb_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master
//   APB3 initiator. Accepts one command at a time over a valid/ready
//   interface, runs it as a SETUP + ACCESS transfer on the APB bus and
//   returns a single-cycle response. A transfer whose slave holds PREADY
//   low for TIMEOUT consecutive ACCESS cycles is aborted with rsp_err=1
//   (TIMEOUT=0 waits forever).
//
// Ports
//   PCLK, PRESETn              clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_write/addr/wdata       command direction, address, write data
//   rsp_valid/rsp_rdata/err    one-cycle completion pulse, read data, abort flag
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA   APB request outputs (all registered)
//   PRDATA/PREADY              APB slave response inputs
module apb_master #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value at which the next PREADY=0 is the TIMEOUT-th one.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            PADDR     <= cmd_addr;
            PWRITE    <= cmd_write;
            PWDATA    <= cmd_wdata;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            cmd_ready <= 1'b0;
            state     <= SETUP;
          end else begin
            // Raised on the first edge after reset release and kept high
            // while idle.
            cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            wait_cnt  <= '0;
            // Back in IDLE with cmd_ready already high, so a new command
            // can be taken on the response cycle.
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            wait_cnt  <= '0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          cmd_ready <= 1'b0;
          wait_cnt  <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master
//   Self-checking bench for apb_master. A behavioural APB slave (zero-wait,
//   registered-PREADY, stuck-low or random-wait) sits on the bus; expected
//   responses come from a reference memory and a transfer-length rule
//   (ACCESS ends at the first PREADY=1 among the first TIMEOUT cycles,
//   otherwise it is aborted after exactly TIMEOUT cycles).
module tb_apb_master;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Behavioural slave. Mode 0: PREADY tied high. Mode 1: registered PREADY
  // (one wait state, clears when PSEL drops). Mode 2: PREADY stuck low.
  // Mode 3: random PREADY every cycle.
  int          slave_mode = 0;
  logic [31:0] smem [16];

  function automatic logic [31:0] init_val(input int i);
    return (i == 1) ? 32'h1234_5678 : 32'h0101_0101 * i;
  endfunction

  always @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int i = 0; i < 16; i++) smem[i] <= init_val(i);
      PREADY <= 1'b0;
    end else begin
      case (slave_mode)
        0:       PREADY <= 1'b1;
        1:       PREADY <= PSEL && PENABLE && !PREADY;
        2:       PREADY <= 1'b0;
        default: PREADY <= ($urandom_range(0, 7) == 0);
      endcase
      if (PSEL && PENABLE && PREADY && PWRITE) smem[PADDR] <= PWDATA;
    end
  end

  assign PRDATA = smem[PADDR];

  logic [31:0] ref_mem [16];

  task automatic init_ref();
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_psel"},      PSEL,      0);
    check({tag, "_penable"},   PENABLE,   0);
    check({tag, "_paddr"},     PADDR,     0);
    check({tag, "_pwrite"},    PWRITE,    0);
    check({tag, "_pwdata"},    PWDATA,    0);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"},   rsp_err,   0);
  endtask

  // Runs one transfer from a negedge. Returns the number of ACCESS cycles
  // observed and the response data/error.
  task automatic do_txn(input bit wr, input logic [3:0] a, input logic [31:0] d,
                        output int acc_n, output logic [31:0] rd, output bit err);
    bit          rq[$];
    int          cyc;
    int          psel_n;
    int          model_len;
    bit          stable;
    bit          exp_err;
    logic [31:0] exp_rd;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin @(negedge PCLK); cyc++; end
    check("accept_wait", 64'(cyc < 20), 1);
    @(negedge PCLK);
    // Command inputs change while busy; the bus must not follow.
    cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = ~d; cmd_write = !wr;

    psel_n = 0; acc_n = 0; stable = 1'b1; cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      if (PSEL) begin
        psel_n++;
        if (PADDR !== a || PWRITE !== wr || PWDATA !== d) stable = 1'b0;
      end
      if (PSEL && PENABLE) begin
        acc_n++;
        rq.push_back(PREADY);
      end
      @(negedge PCLK); cyc++;
    end

    model_len = TIMEOUT; exp_err = 1'b1;
    foreach (rq[i]) if (rq[i] && i < TIMEOUT && exp_err) begin
      model_len = i + 1; exp_err = 1'b0;
    end
    exp_rd = (wr || exp_err) ? 32'h0 : ref_mem[a];

    check("rsp_seen",      rsp_valid,  1);
    check("setup_1cycle",  psel_n,     acc_n + 1);
    check("access_len",    acc_n,      model_len);
    check("bus_stable",    stable,     1);
    check("rsp_err",       rsp_err,    exp_err);
    check("rsp_rdata",     rsp_rdata,  exp_rd);
    check("rsp_cmd_ready", cmd_ready,  1);
    check("rsp_psel_low",  PSEL,       0);
    rd = rsp_rdata; err = rsp_err;
    if (wr && !exp_err) ref_mem[a] = d;
    @(negedge PCLK);
    check("rsp_one_cycle", rsp_valid,  0);
  endtask

  initial begin
    int          acc;
    logic [31:0] rd;
    logic [31:0] wd;
    bit          err;
    int          cyc;

    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    init_ref();
    repeat (3) @(negedge PCLK);
    check_reset_outputs("rst");
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("rst_ready_after_release", cmd_ready, 1);

    // Zero-wait write
    slave_mode = 0;
    do_txn(1'b1, 4'h2, 32'hA5A5_0001, acc, rd, err);
    check("wr0_access_cycles", acc, 1);
    check("wr0_err", err, 0);

    // One-wait read
    slave_mode = 1;
    do_txn(1'b0, 4'h1, 32'h0, acc, rd, err);
    check("rd1_access_cycles", acc, 2);
    check("rd1_data", rd, 32'h1234_5678);

    // Timeout then normal recovery
    slave_mode = 2;
    do_txn(1'b0, 4'h5, 32'h0, acc, rd, err);
    check("to_access_cycles", acc, TIMEOUT);
    check("to_err", err, 1);
    check("to_rdata", rd, 0);
    slave_mode = 0;
    do_txn(1'b0, 4'h2, 32'h0, acc, rd, err);
    check("after_to_data", rd, 32'hA5A5_0001);
    check("after_to_err", err, 0);

    // Back-to-back with cmd_valid held high
    slave_mode = 1;
    wd = $urandom;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h3; cmd_wdata = wd;
    cyc = 0;
    while (!PSEL && cyc < 20) begin @(negedge PCLK); cyc++; end
    check("b2b_first_start", PSEL, 1);
    cmd_write = 1'b0; cmd_wdata = '0;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin @(negedge PCLK); cyc++; end
    check("b2b_wr_rsp", rsp_valid, 1);
    check("b2b_wr_err", rsp_err, 0);
    check("b2b_gap_psel", PSEL, 0);
    check("b2b_gap_ready", cmd_ready, 1);
    @(negedge PCLK);
    check("b2b_rd_accepted_psel", PSEL, 1);
    check("b2b_rd_setup_penable", PENABLE, 0);
    check("b2b_rd_pwrite", PWRITE, 0);
    check("b2b_rd_paddr", PADDR, 3);
    cmd_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin @(negedge PCLK); cyc++; end
    check("b2b_rd_rsp", rsp_valid, 1);
    check("b2b_rd_data", rsp_rdata, wd);
    ref_mem[3] = wd;
    @(negedge PCLK);

    // Randomized traffic across all slave behaviours
    for (int n = 0; n < 40; n++) begin
      slave_mode = $urandom_range(0, 3);
      do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, acc, rd, err);
    end

    // Reset in the middle of ACCESS
    slave_mode = 2;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h7; cmd_wdata = '0;
    cyc = 0;
    while (!PENABLE && cyc < 20) begin
      @(negedge PCLK); cyc++;
      if (PSEL) cmd_valid = 1'b0;
    end
    check("mid_rst_in_access", PENABLE, 1);
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b0;
    @(negedge PCLK);
    check_reset_outputs("mid_rst");
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("mid_rst_ready_back", cmd_ready, 1);
    check("mid_rst_no_rsp", rsp_valid, 0);
    init_ref();
    slave_mode = 0;
    do_txn(1'b0, 4'h1, 32'h0, acc, rd, err);
    check("post_rst_read", rd, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

endmodule
